wb_write_arbiter: RTL and testbench

Write-back arbiter that owns the register file's single write port. It merges single-cycle ALU results with results from long-latency units (load/multiply) into at most one register write per cycle. Long-latency results are buffered in a small FIFO, and a starvation guard forces periodic drains. Outputs are registered on `posedge clk` so they are stable before the register file commits on `negedge clk`.

---
 rtl/wb_write_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Write-back arbiter owning the register file write port: ALU results win by default,
// long-latency results queue in a FIFO, and a starvation guard forces periodic drains.
module wb_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_addr,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          stall_alu,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_WIDTH-1:0]         lu_addr,
  input  logic [DATA_WIDTH-1:0]         lu_data,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         addressWrite,
  output logic [DATA_WIDTH-1:0]         dataWrite,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [STARVE_W-1:0] starveCnt;
  logic [STARVE_W-1:0] starveNext;
  logic [STARVE_W-1:0] starveInc;

  logic [ADDR_WIDTH-1:0] memAddr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] memData [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr;
  logic [PTR_W-1:0]      wrPtr;

  logic fifoEmpty;
  logic aluWin;
  logic doPop;
  logic doPush;

  // Ready is deliberately conservative: a full buffer refuses even when it pops.
  assign fifoEmpty = (fifo_count == '0);
  assign lu_ready  = rst && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign stall_alu = (state == ST_DRAIN);
  assign starveInc = starveCnt + STARVE_W'(1);

  // Arbitration and starvation guard next-state.
  always_comb begin
    stateNext  = state;
    starveNext = starveCnt;
    aluWin     = alu_valid && (state == ST_RUN);
    doPop      = !aluWin && !fifoEmpty;
    doPush     = lu_valid && lu_ready;
    case (state)
      ST_RUN: begin
        if (doPop || fifoEmpty) begin
          starveNext = '0;
        end else if (starveInc == STARVE_W'(STARVE_LIMIT)) begin
          starveNext = '0;
          stateNext  = ST_DRAIN;
        end else begin
          starveNext = starveInc;
        end
      end
      ST_DRAIN: begin
        starveNext = '0;
        stateNext  = ST_RUN;
      end
      default: begin
        starveNext = '0;
        stateNext  = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveNext;
    end
  end

  // Buffer storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      memAddr[wrPtr] <= lu_addr;
      memData[wrPtr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Write port; address and data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeEnable  <= 1'b0;
      addressWrite <= '0;
      dataWrite    <= '0;
    end else if (aluWin) begin
      writeEnable  <= 1'b1;
      addressWrite <= alu_addr;
      dataWrite    <= alu_data;
    end else if (doPop) begin
      writeEnable  <= 1'b1;
      addressWrite <= memAddr[rdPtr];
      dataWrite    <= memData[rdPtr];
    end else begin
      writeEnable  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_write_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          stall_alu;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          writeEnable;
  logic [AW-1:0] addressWrite;
  logic [DW-1:0] dataWrite;
  logic [2:0]    fifo_count;

  wb_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .stall_alu(stall_alu),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .writeEnable(writeEnable), .addressWrite(addressWrite), .dataWrite(dataWrite),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  bit cmpOn   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending results plus the starvation rules.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mq[$];
  bit            mStall;
  int            mStarve;
  bit            mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;

  task automatic modelStep();
    int     preSize;
    bit     aluTakes;
    entry_t head;
    preSize  = mq.size();
    aluTakes = alu_valid && !mStall;
    if (aluTakes) begin
      mWe <= 1'b1; mAddr <= alu_addr; mData <= alu_data;
    end else if (preSize > 0) begin
      head = mq.pop_front();
      mWe <= 1'b1; mAddr <= head.addr; mData <= head.data;
    end else begin
      mWe <= 1'b0;
    end
    if (mStall) begin
      mStall <= 1'b0; mStarve <= 0;
    end else if (preSize == 0 || !aluTakes) begin
      mStarve <= 0;
    end else if (mStarve + 1 == LIMIT) begin
      mStarve <= 0; mStall <= 1'b1;
    end else begin
      mStarve <= mStarve + 1;
    end
    if (lu_valid && preSize < DEPTH) mq.push_back('{lu_addr, lu_data});
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mStall <= 1'b0; mStarve <= 0; mWe <= 1'b0; mAddr <= '0; mData <= '0;
    end else begin
      modelStep();
    end
  end

  always @(negedge clk) begin
    if (cmpOn) begin
      check("cmp_writeEnable", 64'(writeEnable), 64'(mWe));
      check("cmp_addressWrite", 64'(addressWrite), 64'(mAddr));
      check("cmp_dataWrite", 64'(dataWrite), 64'(mData));
      check("cmp_stall_alu", 64'(stall_alu), 64'(mStall));
      check("cmp_fifo_count", 64'(fifo_count), 64'(mq.size()));
      check("cmp_lu_ready", 64'(lu_ready), 64'((rst && mq.size() < DEPTH) ? 1 : 0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic edgeDrive();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    #1 rst = 1'b0;
    #1 cmpOn = 1'b1;

    // Reset held
    @(negedge clk); @(negedge clk);
    check("rst_we", 64'(writeEnable), 64'd0);
    check("rst_addr", 64'(addressWrite), 64'd0);
    check("rst_data", 64'(dataWrite), 64'd0);
    check("rst_stall", 64'(stall_alu), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ready", 64'(lu_ready), 64'd0);
    edgeDrive();
    rst = 1'b1;
    #1;
    check("rel_ready", 64'(lu_ready), 64'd1);
    check("rel_count", 64'(fifo_count), 64'd0);

    // ALU only
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'd5;
    edgeDrive();
    alu_valid = 1'b0;
    @(negedge clk);
    check("alu_we", 64'(writeEnable), 64'd1);
    check("alu_addr", 64'(addressWrite), 64'd10);
    check("alu_data", 64'(dataWrite), 64'd5);
    @(negedge clk);
    check("alu_we_off", 64'(writeEnable), 64'd0);
    check("alu_hold_addr", 64'(addressWrite), 64'd10);

    // Long-latency only
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'hDEADBEEF;
    edgeDrive();
    lu_valid = 1'b0;
    @(negedge clk);
    check("ll_count1", 64'(fifo_count), 64'd1);
    check("ll_no_bypass", 64'(writeEnable), 64'd0);
    @(negedge clk);
    check("ll_we", 64'(writeEnable), 64'd1);
    check("ll_addr", 64'(addressWrite), 64'd3);
    check("ll_data", 64'(dataWrite), 64'hDEADBEEF);
    check("ll_count0", 64'(fifo_count), 64'd0);

    // Starvation guard
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
    edgeDrive();
    lu_valid = 1'b0; alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h101;
    edgeDrive();
    alu_data = 32'h102;
    @(negedge clk);
    check("stv_e1_data", 64'(dataWrite), 64'h101);
    check("stv_e1_count", 64'(fifo_count), 64'd1);
    check("stv_e1_stall", 64'(stall_alu), 64'd0);
    edgeDrive();
    alu_data = 32'h103;
    edgeDrive();
    alu_data = 32'h104;
    @(negedge clk);
    check("stv_e3_data", 64'(dataWrite), 64'h103);
    check("stv_e3_stall", 64'(stall_alu), 64'd1);
    edgeDrive();
    @(negedge clk);
    check("stv_e4_addr", 64'(addressWrite), 64'd7);
    check("stv_e4_data", 64'(dataWrite), 64'h77);
    check("stv_e4_stall", 64'(stall_alu), 64'd0);
    check("stv_e4_count", 64'(fifo_count), 64'd0);
    edgeDrive();
    alu_valid = 1'b0;
    @(negedge clk);
    check("stv_e5_data", 64'(dataWrite), 64'h104);
    check("stv_e5_addr", 64'(addressWrite), 64'd1);

    // Full buffer with ALU pressure
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h200;
    lu_valid  = 1'b1; lu_addr  = 5'd20; lu_data = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      edgeDrive();
      alu_data = 32'h200 + DW'(i);
      lu_addr  = 5'd20 + AW'(i);
      lu_data  = 32'h300 + DW'(i);
    end
    @(negedge clk);
    check("full_count4", 64'(fifo_count), 64'd4);
    check("full_ready0", 64'(lu_ready), 64'd0);
    check("full_stall", 64'(stall_alu), 64'd1);
    check("full_aluaddr0", 64'(addressWrite), 64'd0);
    edgeDrive();
    @(negedge clk);
    check("full_pop_ready", 64'(lu_ready), 64'd1);
    check("full_pop_count", 64'(fifo_count), 64'd3);
    check("full_pop_data", 64'(dataWrite), 64'h300);
    edgeDrive();
    alu_valid = 1'b0; lu_valid = 1'b0;
    @(negedge clk);
    check("full_5th_count", 64'(fifo_count), 64'd4);
    check("full_5th_alu", 64'(dataWrite), 64'h204);
    repeat (4) @(negedge clk);
    check("drain_count", 64'(fifo_count), 64'd0);
    check("drain_addr", 64'(addressWrite), 64'd24);
    check("drain_data", 64'(dataWrite), 64'h304);

    // Reset mid-operation
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
    edgeDrive();
    lu_data = 32'h56;
    edgeDrive();
    lu_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    check("mid_count2", 64'(fifo_count), 64'd2);
    check("mid_we1", 64'(writeEnable), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_we", 64'(writeEnable), 64'd0);
    check("mid_rst_ready", 64'(lu_ready), 64'd0);
    edgeDrive();
    edgeDrive();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_stale_we", 64'(writeEnable), 64'd0);
      check("mid_no_stale_count", 64'(fifo_count), 64'd0);
    end

    cmpOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
